// File: rtl/sel_arb_if.sv
// Handshake bundle between N requesters, the selector and one downstream consumer.
// The slave modport is the selector's view; the master modport is the surroundings.
interface sel_arb_if #(
   parameter int N = 4,
   parameter int W = 32
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]     i_req_vld;
   logic [N*W-1:0]   i_req_data;
   logic [N-1:0]     o_req_rdy;
   logic             o_vld;
   logic [W-1:0]     o_data;
   logic [IDX_W-1:0] o_idx;
   logic             i_rdy;

   // Valid/ready: a beat moves on a cycle where its valid and ready are both high.
   // Valid carries no obligation to persist, and ready never depends on payload data.
   modport slave (
      input  i_req_vld, i_req_data, i_rdy,
      output o_req_rdy, o_vld, o_data, o_idx
   );

   modport master (
      output i_req_vld, i_req_data, i_rdy,
      input  o_req_rdy, o_vld, o_data, o_idx
   );
endinterface

// File: rtl/sel_arb.sv
// Round-robin selector: picks one of N requesters into a single-entry output register
// that drains and reloads in the same cycle when the consumer accepts.
module sel_arb #(
   parameter  int N     = 4,
   parameter  int W     = 32,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   sel_arb_if.slave         bus,
   output logic             o_dbg_state,
   output logic [IDX_W-1:0] o_dbg_ptr
);
   typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     data_q, data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic             can_load;
   logic             found;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] cand;
   logic [N-1:0]     rdy;
   logic             xfer_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      can_load = (state_q == EMPTY) || bus.i_rdy;
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      rdy      = '0;
      state_d  = state_q;
      data_d   = data_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;

      // Scan ptr, ptr+1, ... wrapping at N; first valid requester wins.
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr_q) + off >= N) ? IDX_W'(int'(ptr_q) + off - N)
                                         : IDX_W'(int'(ptr_q) + off);
         if (!found && bus.i_req_vld[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end

      if (!rst && found) begin
         rdy[win] = can_load;
      end
      xfer_in = !rst && found && can_load;

      if (xfer_in) begin
         state_d = FULL;
         data_d  = bus.i_req_data[W*win +: W];
         idx_d   = win;
         ptr_d   = (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
      end else if (state_q == FULL && bus.i_rdy) begin
         state_d = EMPTY;
      end
   end

   assign bus.o_req_rdy = rdy;
   assign bus.o_vld     = (state_q == FULL);
   assign bus.o_data    = data_q;
   assign bus.o_idx     = idx_q;
   assign o_dbg_state   = (state_q == FULL);
   assign o_dbg_ptr     = ptr_q;
endmodule

// File: tb/tb_sel_arb.sv
// Bench for sel_arb: directed round-robin, stall, wrap, withdrawal and reset scenarios,
// then random traffic checked against a rotation model and an expected-beat queue.
module tb_sel_arb;
   localparam int N     = 4;
   localparam int W     = 8;
   localparam int IDX_W = 2;

   logic clk;
   logic rst;
   logic             dbg_state;
   logic [IDX_W-1:0] dbg_ptr;
   logic             dbg_state1;
   logic [0:0]       dbg_ptr1;

   sel_arb_if #(.N(N), .W(W)) bus ();
   sel_arb_if #(.N(1), .W(W)) bus1 ();

   sel_arb #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state),
      .o_dbg_ptr   (dbg_ptr)
   );

   sel_arb #(.N(1), .W(W)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus1),
      .o_dbg_state (dbg_state1),
      .o_dbg_ptr   (dbg_ptr1)
   );

   assign bus1.i_req_vld  = bus.i_req_vld[0];
   assign bus1.i_req_data = bus.i_req_data[W-1:0];
   assign bus1.i_rdy      = bus.i_rdy;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard / model ----------------
   logic [IDX_W+W-1:0] exp_q[$];
   int                 m_ptr  = 0;
   logic               m_full = 1'b0;
   logic               prev_hold = 1'b0;
   logic [W-1:0]       prev_data;
   logic [IDX_W-1:0]   prev_idx;

   // Rotate a doubled copy of the request vector so the lowest set bit is the winner.
   function automatic int model_winner(input logic [N-1:0] v, input int p);
      logic [2*N-1:0] dbl;
      dbl = {v, v} >> p;
      for (int j = 0; j < N; j++) begin
         if (dbl[j]) return (p + j) % N;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [N-1:0]       exp_rdy;
      logic [IDX_W+W-1:0] e;
      int                 w;
      logic               in_x;
      logic               out_x;

      exp_rdy = '0;
      w = model_winner(bus.i_req_vld, m_ptr);
      if (!rst && w >= 0 && (!m_full || bus.i_rdy)) exp_rdy[w] = 1'b1;
      check("rdy", 64'(bus.o_req_rdy), 64'(exp_rdy));

      if (!rst) begin
         check("rdy_onehot0", 64'($onehot0(bus.o_req_rdy)), 64'd1);
         check("o_vld", 64'(bus.o_vld), 64'(m_full));
         check("ptr", 64'(dbg_ptr), 64'(m_ptr));
         check("ptr_range", 64'(int'(dbg_ptr) < N), 64'd1);
         if (prev_hold) begin
            check("hold_data", 64'(bus.o_data), 64'(prev_data));
            check("hold_idx", 64'(bus.o_idx), 64'(prev_idx));
         end
         check("n1_rdy", 64'(bus1.o_req_rdy),
               64'(bus1.i_req_vld && (!bus1.o_vld || bus1.i_rdy)));
         check("n1_idx", 64'(bus1.o_idx), 64'd0);
         check("n1_ptr", 64'(dbg_ptr1), 64'd0);
      end

      if (rst) begin
         exp_q.delete();
         m_ptr  = 0;
         m_full = 1'b0;
      end else begin
         out_x = bus.o_vld && bus.i_rdy;
         in_x  = (exp_rdy != '0);
         if (out_x) begin
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 64'(bus.o_vld), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat", 64'({bus.o_idx, bus.o_data}), 64'(e));
            end
         end
         if (in_x) begin
            exp_q.push_back({IDX_W'(w), bus.i_req_data[W*w +: W]});
            m_ptr = (w + 1) % N;
         end
         m_full = in_x ? 1'b1 : (out_x ? 1'b0 : m_full);
      end

      prev_hold = !rst && bus.o_vld && !bus.i_rdy;
      prev_data = bus.o_data;
      prev_idx  = bus.o_idx;
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] vld, input logic rdy);
      bus.i_req_vld = vld;
      bus.i_rdy     = rdy;
   endtask

   initial begin
      rst = 1'b1;
      bus.i_req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      drive(4'b1111, 1'b1);
      repeat (2) tick();
      @(negedge clk);
      check("rst_vld", 64'(bus.o_vld), 64'd0);
      check("rst_idx", 64'(bus.o_idx), 64'd0);
      check("rst_data", 64'(bus.o_data), 64'd0);
      check("rst_ptr", 64'(dbg_ptr), 64'd0);
      check("rst_rdy", 64'(bus.o_req_rdy), 64'd0);
      tick();
      rst = 1'b0;

      // all requesting, consumer always ready: strict rotation
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("rr_idx", 64'(bus.o_idx), 64'((i - 1) % 4));
            check("rr_data", 64'(bus.o_data), 64'(8'h10 + (i - 1) % 4));
         end
         check("rr_grant", 64'(bus.o_req_rdy), 64'(4'b0001 << (i % 4)));
         tick();
      end

      // stall with requester 2 held
      drive(4'b0100, 1'b1);
      @(negedge clk);
      check("stall_setup", 64'(bus.o_req_rdy), 64'b0100);
      tick();
      drive(4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_rdy", 64'(bus.o_req_rdy), 64'd0);
         check("stall_vld", 64'(bus.o_vld), 64'd1);
         check("stall_idx", 64'(bus.o_idx), 64'd2);
         check("stall_data", 64'(bus.o_data), 64'h12);
         tick();
      end
      drive(4'b0001, 1'b1);
      @(negedge clk);
      check("passthru_rdy", 64'(bus.o_req_rdy), 64'b0001);
      tick();

      // wrap from pointer 3 back to 0
      drive(4'b0100, 1'b1);
      @(negedge clk);
      check("passthru_vld", 64'(bus.o_vld), 64'd1);
      check("passthru_idx", 64'(bus.o_idx), 64'd0);
      check("passthru_ptr", 64'(dbg_ptr), 64'd1);
      tick();
      drive(4'b1001, 1'b1);
      @(negedge clk);
      check("wrap_ptr3", 64'(dbg_ptr), 64'd3);
      check("wrap_grant3", 64'(bus.o_req_rdy), 64'b1000);
      tick();
      @(negedge clk);
      check("wrap_idx3", 64'(bus.o_idx), 64'd3);
      check("wrap_ptr0", 64'(dbg_ptr), 64'd0);
      check("wrap_grant0", 64'(bus.o_req_rdy), 64'b0001);
      tick();

      // requester 1 pulses while the output is stalled
      drive(4'b0010, 1'b0);
      @(negedge clk);
      check("wd_idx", 64'(bus.o_idx), 64'd0);
      check("wd_ptr1", 64'(dbg_ptr), 64'd1);
      check("wd_rdy", 64'(bus.o_req_rdy), 64'd0);
      tick();
      drive(4'b0000, 1'b0);
      @(negedge clk);
      check("wd_vld", 64'(bus.o_vld), 64'd1);
      check("wd_ptr", 64'(dbg_ptr), 64'd1);
      tick();

      // reset while holding requester 3
      drive(4'b1000, 1'b1);
      @(negedge clk);
      check("pre_rst_grant", 64'(bus.o_req_rdy), 64'b1000);
      tick();
      rst = 1'b1;
      drive(4'b0000, 1'b0);
      @(negedge clk);
      check("pre_rst_idx", 64'(bus.o_idx), 64'd3);
      tick();
      rst = 1'b0;
      drive(4'b1010, 1'b1);
      @(negedge clk);
      check("post_rst_vld", 64'(bus.o_vld), 64'd0);
      check("post_rst_ptr", 64'(dbg_ptr), 64'd0);
      check("post_rst_grant", 64'(bus.o_req_rdy), 64'b0010);
      tick();
      drive(4'b0000, 1'b1);
      @(negedge clk);
      check("post_rst_idx", 64'(bus.o_idx), 64'd1);
      check("post_rst_data", 64'(bus.o_data), 64'h11);
      tick();

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         bus.i_req_data = $urandom;
         drive(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
         tick();
      end

      rst = 1'b0;
      drive(4'b0000, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      check("drain_queue", 64'(exp_q.size()), 64'd0);
      check("drain_vld", 64'(bus.o_vld), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sel_arb.md
SEL_ARB -- requirements
Module: sel_arb

Interface
REQ-001 Parameter N, default 4, number of requesters; SHALL be at least 1.
REQ-002 Parameter W, default 32, payload width per requester.
REQ-003 Localparam IDX_W = (N > 1) ? $clog2(N) : 1, the grant index width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 i_req_vld  in  N  per-requester valid.
REQ-007 i_req_data  in  N*W  packed payloads; requester k occupies bits [W*k +: W].
REQ-008 o_req_rdy  out  N  per-requester accept; one-hot or zero.
REQ-009 o_vld  out  1  output register holds a valid beat.
REQ-010 o_data  out  W  payload of the held beat.
REQ-011 o_idx  out  IDX_W  index of the requester that supplied the held beat.
REQ-012 i_rdy  in  1  downstream accept of the held beat.

Function
REQ-013 Input transfer k: i_req_vld[k] && o_req_rdy[k]. Output transfer: o_vld && i_rdy.
REQ-014 Output register (o_vld/o_data/o_idx) is the only storage besides the pointer: one entry; states EMPTY (o_vld=0) and FULL (o_vld=1).
REQ-015 can_load = !o_vld || i_rdy (pass-through drain: load in the same cycle the held beat leaves).
REQ-016 Round-robin pointer ptr (IDX_W bits, range 0..N-1): winner = first k with i_req_vld[k], searched ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-017 o_req_rdy[winner] = can_load; all other o_req_rdy bits 0; all bits 0 when no i_req_vld bit is set. Combinational from i_req_vld, ptr, o_vld, i_rdy.
REQ-018 o_req_rdy SHALL NOT depend on i_req_data.
REQ-019 On an input transfer from k: next o_vld=1, o_data=i_req_data[W*k +: W], o_idx=k, ptr = (k==N-1) ? 0 : k+1.
REQ-020 Output transfer with no input transfer: next o_vld=0; o_data/o_idx hold their value.
REQ-021 No transfer of either kind: all state holds; ptr changes only on an input transfer.
REQ-022 Latency: a beat accepted in cycle t is on o_data with o_vld=1 in cycle t+1; throughput is one beat per cycle while i_rdy=1.
REQ-023 FULL && !i_rdy: o_req_rdy=0, and o_vld/o_data/o_idx are stable until i_rdy=1.
REQ-024 Requesters may deassert i_req_vld without a transfer; arbitration is re-evaluated each cycle and carries no grant lock.
REQ-025 Fairness: with all N requesters continuously valid and i_rdy=1, grants are issued in strict rotation; no requester waits more than N-1 grants.
REQ-026 N=1: ptr is constant 0, o_idx=0, and o_req_rdy[0] = can_load whenever i_req_vld[0]=1.

Reset
REQ-027 While rst=1: o_vld=0, o_idx=0, o_data=0, ptr=0, o_req_rdy=0.
REQ-028 Reset mid-operation discards the held beat without an output transfer; the first cycle after rst deasserts behaves as EMPTY with ptr=0.
REQ-029 No assertion checks SHALL fire while rst=1.

Verification
REQ-030 The bench SHALL assert: o_req_rdy is onehot0; o_vld && !i_rdy implies o_data/o_idx stable next cycle; ptr < N.
REQ-031 N=4, W=8, i_req_vld=4'b1111, data k=8'h10+k, i_rdy=1 for 8 cycles -> o_idx sequence 0,1,2,3,0,1,2,3; o_data 10,11,12,13,10,...
REQ-032 Stall: FULL with o_idx=2, i_rdy=0 for 3 cycles -> o_req_rdy=0, beat held; i_rdy=1 with i_req_vld=4'b0001 -> same-cycle load, next o_idx=0, o_vld stays 1.
REQ-033 Wrap: ptr=3, i_req_vld=4'b1001 -> grant 3 then ptr=0; next grant 0 then ptr=1.
REQ-034 Withdrawal: i_req_vld[1] pulses for one cycle while FULL && !i_rdy -> no transfer from 1, ptr unchanged, o_vld held.
REQ-035 Reset mid-stream: rst=1 while FULL with o_idx=3 -> next cycle o_vld=0, ptr=0; after release with i_req_vld=4'b1010 -> grant 1.
